alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the combinational ARMv4 ALU. It accepts one operation at a time on a valid/ready input channel. ARM data-processing ops complete in one cycle; 2*WIDTH-bit multiplies (and optionally divides) run iteratively. Results and NZCV flags are held in an output register until the consumer takes them. It sits between the register-read stage and writeback of the core.

## Interface

**Parameters**

- WIDTH, 32: operand width; must be ≥ 4.

**Ports**

- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: operation offered.
- in_ready, output, 1: operation accepted on a cycle where in_valid && in_ready.
- a, input, WIDTH: operand Rn.
- b, input, WIDTH: operand Op2.
- alu_sel, input, 4: ARM DP opcode, 0..F = AND EOR SUB RSB ADD ADC SBC RSC TST TEQ CMP CMN ORR MOV BIC MVN.
- mode, input, 2: 00 = DP, 01 = UMULL, 10 = SMULL, 11 = UDIV.
- flags_in, input, 4: current NZCV; C is the carry-in.
- out_valid, output, 1: result held.
- out_ready, input, 1: result consumed on a cycle where out_valid && out_ready.
- alu_out, output, 2*WIDTH: result.
- nzcv, output, 4: result flags.
- out_wb, output, 1: result is to be written back; 0 for TST/TEQ/CMP/CMN.

## Operation

**Acceptance**

- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Operands, alu_sel, mode and flags_in are captured at acceptance.

**States**

- IDLE: on acceptance with mode 00, go to DONE with the result registered that edge. Mode 01/10 goes to MUL; mode 11 goes to DIV.
- MUL: shift-add, one multiplier bit per cycle, WIDTH iterations.
  - SMULL: operands are converted to magnitudes at entry, and the product is negated at the end if the signs differ.
  - Then go to DONE.
- DIV: restoring divide, one quotient bit per cycle, WIDTH iterations.
  - alu_out = {remainder, quotient}.
  - Then go to DONE.
- DONE: out_valid = 1. Go to IDLE on out_ready. A new op may be accepted in that same cycle, because in_ready is combinational on out_ready.

**DP arithmetic** (WIDTH bits, zero-extended into alu_out[2*WIDTH-1:WIDTH])

- SUB/CMP: a + ~b + 1.
- RSB: b + ~a + 1.
- ADC: a + b + C.
- SBC: a + ~b + C.
- RSC: b + ~a + C.
- C is the adder carry-out (ARM not-borrow).
- V = signed overflow of the WIDTH-bit add.
- Logical ops: C and V are passed from flags_in.
- MOV/MVN ignore a.

**Flags**

- N = MSB of the result width: bit WIDTH-1 for DP, bit 2*WIDTH-1 for MUL/DIV.
- Z = result is all zero over that width.
- MUL: C and V are passed from flags_in.
- DIV: C is passed from flags_in; V = 1 only on divide-by-zero.
  - Divide-by-zero still runs WIDTH cycles and yields quotient = all ones, remainder = a.

**Writeback and mode 11 without the divider**

- out_wb = 0 for alu_sel 8..B in DP mode, otherwise 1.
- With the divider compiled out, mode 11 is treated as DP mode 00.

**Reset**

- Asynchronous reset at any time, including mid-MUL/DIV, forces:
  - state IDLE, out_valid 0, in_ready 0 while asserted;
  - alu_out 0, nzcv 0, out_wb 0;
  - iteration counter 0.
- The aborted operation is discarded and produces no output.

## Timing

- DP: accepted at edge k; out_valid high after edge k+1 (1-cycle latency).
- MUL/DIV: out_valid high after edge k+WIDTH+1.
- Outputs are stable while out_valid && !out_ready; backpressure holds the result indefinitely.
- Back-to-back DP with out_ready held at 1 gives one result per cycle.
- in_ready depends combinationally on out_ready only; there is no combinational path from a/b to any output.

## Configuration

- ALU_SEQ_DIV_EN defined: the DIV state, divider datapath and mode 11 are implemented as above.
- ALU_SEQ_DIV_EN undefined:
  - no divider logic is built;
  - mode 11 executes as DP;
  - the DIV state is unreachable.

## Test plan

- WIDTH=32, ADD (alu_sel 4), a=1, b=1, flags_in=0 → 1 cycle later alu_out=2, nzcv=0000, out_wb=1.
- CMP (alu_sel A), a=5, b=5 → alu_out=0, nzcv=0110 (Z, C set), out_wb=0. Then ADD with a=7FFFFFFF, b=1 → alu_out=80000000, nzcv=1001.
- SMULL, a=FFFFFFFE (−2), b=3 → out_valid exactly 33 cycles after acceptance, alu_out=FFFFFFFF_FFFFFFFA, N=1, C/V equal to flags_in.
- With ALU_SEQ_DIV_EN: UDIV a=100, b=7 → alu_out={2,14} (remainder 2, quotient 14). UDIV with b=0 → quotient FFFFFFFF, remainder=a, V=1.
- Backpressure: out_ready low for 10 cycles after a DP result → alu_out/nzcv unchanged and in_ready=0. Raising out_ready with in_valid high accepts the next op in that same cycle.
- Reset deasserted-low at cycle 10 of a UMULL → out_valid=0, in_ready=0 while reset is low. After release: in_ready=1, no stale result; the next ADD completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ARMv4 ALU with iterative 2*WIDTH-bit multiply and optional divide.
//   Ports: clk, reset (async, active low);
//          in_valid/in_ready plus a, b, alu_sel, mode, flags_in form the operation channel;
//          out_valid/out_ready plus alu_out, nzcv, out_wb form the result channel.
//   mode: 00 DP, 01 UMULL, 10 SMULL, 11 UDIV (DP when the divider is not built).
//   Define ALU_SEQ_DIV_EN to build the restoring divider.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         alu_sel,
    input  logic [1:0]         mode,
    input  logic [3:0]         flags_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] alu_out,
    output logic [3:0]         nzcv,
    output logic               out_wb
);

    localparam int unsigned W2  = 2 * WIDTH;
    localparam int unsigned WP1 = WIDTH + 1;
    localparam int unsigned CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [1:0]       cv_r;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] mcand;
    logic             neg;
    logic             accept;
    logic             is_dp;
    logic             flags_nz_unused;

    // N and Z of the incoming flags are never consumed
    assign flags_nz_unused = ^flags_in[3:2];

    // IDLE and DONE both accept; DONE frees its slot on out_ready in the same cycle
    assign in_ready = reset && ((state == IDLE) || (state == DONE)) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Mode decode: without the divider, mode 11 falls back to a DP op
    always_comb begin
`ifdef ALU_SEQ_DIV_EN
        is_dp = (mode == 2'b00);
`else
        is_dp = (mode == 2'b00) || (mode == 2'b11);
`endif
    end

    // Single-cycle data-processing result from the live inputs
    logic [WIDTH-1:0] add_x, add_y, dp_res;
    logic             add_cin, dp_arith, dp_wb;
    logic [WIDTH:0]   add_sum;
    logic [3:0]       dp_nzcv;

    always_comb begin
        add_x    = a;
        add_y    = b;
        add_cin  = 1'b0;
        dp_arith = 1'b1;
        dp_res   = '0;
        case (alu_sel)
            4'h0, 4'h8: begin dp_arith = 1'b0; dp_res = a & b; end
            4'h1, 4'h9: begin dp_arith = 1'b0; dp_res = a ^ b; end
            4'h2, 4'hA: begin add_y = ~b; add_cin = 1'b1; end
            4'h3:       begin add_x = b; add_y = ~a; add_cin = 1'b1; end
            4'h4, 4'hB: ;
            4'h5:       add_cin = flags_in[1];
            4'h6:       begin add_y = ~b; add_cin = flags_in[1]; end
            4'h7:       begin add_x = b; add_y = ~a; add_cin = flags_in[1]; end
            4'hC:       begin dp_arith = 1'b0; dp_res = a | b; end
            4'hD:       begin dp_arith = 1'b0; dp_res = b; end
            4'hE:       begin dp_arith = 1'b0; dp_res = a & ~b; end
            default:    begin dp_arith = 1'b0; dp_res = ~b; end
        endcase
        add_sum = {1'b0, add_x} + {1'b0, add_y} + WP1'(add_cin);
        if (dp_arith) dp_res = add_sum[WIDTH-1:0];
        dp_nzcv[3] = dp_res[WIDTH-1];
        dp_nzcv[2] = (dp_res == '0);
        dp_nzcv[1] = dp_arith ? add_sum[WIDTH] : flags_in[1];
        dp_nzcv[0] = dp_arith ? ((add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                                 (dp_res[WIDTH-1] != add_x[WIDTH-1])) : flags_in[0];
        dp_wb      = (alu_sel[3:2] != 2'b10);
    end

    // SMULL works on magnitudes; the sign is restored after the last step
    logic             signed_mul;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign signed_mul = (mode == 2'b10);
    assign a_mag      = (signed_mul && a[WIDTH-1]) ? -a : a;
    assign b_mag      = (signed_mul && b[WIDTH-1]) ? -b : b;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    logic [WIDTH:0]  mul_sum;
    logic [W2-1:0]   prod_next, mul_fin;
    assign mul_sum   = {1'b0, prod[W2-1:WIDTH]} + {1'b0, mcand};
    assign prod_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[W2-1:1]};
    assign mul_fin   = neg ? -prod_next : prod_next;

`ifdef ALU_SEQ_DIV_EN
    // Restoring divide step; a zero divisor naturally gives all-ones quotient and rem = a
    logic [WIDTH-1:0] rem, quot, divisor, rem_next, quot_next;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    assign div_shift = {rem, quot[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, divisor};
    assign div_ge    = !div_diff[WIDTH];
    assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign quot_next = {quot[WIDTH-2:0], div_ge};
`endif

    // Control FSM, iteration datapath and result register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cv_r      <= '0;
            prod      <= '0;
            mcand     <= '0;
            neg       <= 1'b0;
            out_valid <= 1'b0;
            alu_out   <= '0;
            nzcv      <= '0;
            out_wb    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
`endif
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                if (state == DONE) state <= IDLE;
            end
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        cnt  <= '0;
                        cv_r <= flags_in[1:0];
                        if (is_dp) begin
                            alu_out   <= W2'(dp_res);
                            nzcv      <= dp_nzcv;
                            out_wb    <= dp_wb;
                            out_valid <= 1'b1;
                            state     <= DONE;
`ifdef ALU_SEQ_DIV_EN
                        end else if (mode == 2'b11) begin
                            rem     <= '0;
                            quot    <= a;
                            divisor <= b;
                            state   <= DIV;
`endif
                        end else begin
                            prod  <= W2'(b_mag);
                            mcand <= a_mag;
                            neg   <= signed_mul && (a[WIDTH-1] ^ b[WIDTH-1]);
                            state <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        alu_out   <= mul_fin;
                        nzcv      <= {mul_fin[W2-1], (mul_fin == '0), cv_r};
                        out_wb    <= 1'b1;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + CW'(1);
                    end
                end
                DIV: begin
`ifdef ALU_SEQ_DIV_EN
                    if (cnt == CW'(WIDTH - 1)) begin
                        alu_out   <= {rem_next, quot_next};
                        nzcv      <= {rem_next[WIDTH-1], ({rem_next, quot_next} == '0),
                                      cv_r[1], (divisor == '0)};
                        out_wb    <= 1'b1;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        rem  <= rem_next;
                        quot <= quot_next;
                        cnt  <= cnt + CW'(1);
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (WIDTH=32), with hand-computed expectations.
//   Latency is counted in cycles, the acceptance cycle counting as the first.
module tb_alu_seq;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b;
    logic [3:0]    alu_sel;
    logic [1:0]    mode;
    logic [3:0]    flags_in;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] alu_out;
    logic [3:0]    nzcv;
    logic          out_wb;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .mode(mode), .flags_in(flags_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .nzcv(nzcv), .out_wb(out_wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, wait for acceptance, then wait (bounded) for the result
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic [3:0] sel, input logic [1:0] md,
                         input logic [3:0] fl, output int lat);
        int guard;
        a = ta; b = tb; alu_sel = sel; mode = md; flags_in = fl;
        in_valid = 1'b1;
        guard = 0;
        #1;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic expect_res(input string tag, input int lat, input int lat_exp,
                              input logic [63:0] r, input logic [3:0] f, input logic wb);
        check({tag, "_lat"},  64'(lat), 64'(lat_exp));
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_out"},  alu_out, r);
        check({tag, "_nzcv"}, 64'(nzcv), 64'(f));
        check({tag, "_wb"},   64'(out_wb), 64'(wb));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int stale;
        logic [W-1:0]  bb_a [3] = '{32'h0F0, 32'h9, 32'hFF};
        logic [W-1:0]  bb_b [3] = '{32'h00F, 32'h4, 32'h0F};
        logic [3:0]    bb_s [3] = '{4'hC, 4'h2, 4'h1};
        logic [W-1:0]  bb_r [3] = '{32'h0FF, 32'h5, 32'hF0};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; alu_sel = '0; mode = '0; flags_in = '0;
        step(); step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready), 64'd0);
        check("rst_alu_out",   alu_out, 64'd0);
        check("rst_nzcv",      64'(nzcv), 64'd0);
        check("rst_wb",        64'(out_wb), 64'd0);
        reset = 1'b1;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);

        do_op(32'd1, 32'd1, 4'h4, 2'b00, 4'h0, lat);
        expect_res("add", lat, 1, 64'd2, 4'b0000, 1'b1);
        do_op(32'd5, 32'd5, 4'hA, 2'b00, 4'h0, lat);
        expect_res("cmp", lat, 1, 64'd0, 4'b0110, 1'b0);
        do_op(32'h7FFF_FFFF, 32'd1, 4'h4, 2'b00, 4'h0, lat);
        expect_res("add_ovf", lat, 1, 64'h8000_0000, 4'b1001, 1'b1);
        do_op(32'd3, 32'd5, 4'h2, 2'b00, 4'h0, lat);
        expect_res("sub_neg", lat, 1, 64'hFFFF_FFFE, 4'b1000, 1'b1);
        do_op(32'd3, 32'd5, 4'h3, 2'b00, 4'h0, lat);
        expect_res("rsb", lat, 1, 64'd2, 4'b0010, 1'b1);
        do_op(32'd5, 32'd3, 4'h6, 2'b00, 4'h0, lat);
        expect_res("sbc", lat, 1, 64'd1, 4'b0010, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd0, 4'h5, 2'b00, 4'b0010, lat);
        expect_res("adc", lat, 1, 64'd0, 4'b0110, 1'b1);
        do_op(32'd1, 32'd1, 4'h7, 2'b00, 4'h0, lat);
        expect_res("rsc", lat, 1, 64'hFFFF_FFFF, 4'b1000, 1'b1);
        do_op(32'h1234_5678, 32'd0, 4'hF, 2'b00, 4'b0001, lat);
        expect_res("mvn", lat, 1, 64'hFFFF_FFFF, 4'b1001, 1'b1);
        do_op(32'h0F0, 32'h00F, 4'h8, 2'b00, 4'b0010, lat);
        expect_res("tst", lat, 1, 64'd0, 4'b0110, 1'b0);
        do_op(32'h0FF, 32'h00F, 4'hE, 2'b00, 4'h0, lat);
        expect_res("bic", lat, 1, 64'h0F0, 4'b0000, 1'b1);

        do_op(32'hFFFF_FFFE, 32'd3, 4'h0, 2'b10, 4'b0011, lat);
        expect_res("smull", lat, 33, 64'hFFFF_FFFF_FFFF_FFFA, 4'b1011, 1'b1);
        do_op(32'd5, 32'hFFFF_FFFD, 4'h0, 2'b10, 4'b0000, lat);
        expect_res("smull2", lat, 33, 64'hFFFF_FFFF_FFFF_FFF1, 4'b1000, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 2'b01, 4'b0000, lat);
        expect_res("umull", lat, 33, 64'hFFFF_FFFE_0000_0001, 4'b1000, 1'b1);

`ifdef ALU_SEQ_DIV_EN
        do_op(32'd100, 32'd7, 4'h0, 2'b11, 4'b0000, lat);
        expect_res("udiv", lat, 33, {32'd2, 32'd14}, 4'b0000, 1'b1);
        do_op(32'd100, 32'd0, 4'h0, 2'b11, 4'b0010, lat);
        expect_res("udiv0", lat, 33, {32'd100, 32'hFFFF_FFFF}, 4'b0011, 1'b1);
`else
        do_op(32'd2, 32'd3, 4'h4, 2'b11, 4'b0000, lat);
        expect_res("mode3_dp", lat, 1, 64'd5, 4'b0000, 1'b1);
`endif

        // Backpressure: result must hold while out_ready is low
        do_op(32'd1, 32'd1, 4'h4, 2'b00, 4'h0, lat);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_out",   alu_out, 64'd2);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_ready", 64'(in_ready), 64'd0);
        end
        check("bp_nzcv", 64'(nzcv), 64'd0);
        a = 32'd10; b = 32'd20; alu_sel = 4'h4; mode = 2'b00; flags_in = 4'h0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_next_valid", 64'(out_valid), 64'd1);
        check("bp_next_out",   alu_out, 64'd30);

        // Back-to-back DP, one result per cycle
        for (int i = 0; i < 3; i++) begin
            a = bb_a[i]; b = bb_b[i]; alu_sel = bb_s[i];
            step();
            check("b2b_out", alu_out, 64'(bb_r[i]));
        end
        in_valid = 1'b0;
        step();
        check("b2b_drain", 64'(out_valid), 64'd0);
        out_ready = 1'b0;

        // Reset in the middle of a UMULL
        a = 32'd7; b = 32'd9; alu_sel = 4'h0; mode = 2'b01; flags_in = 4'h0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_out",   alu_out, 64'd0);
        check("mid_rst_nzcv",  64'(nzcv), 64'd0);
        step(); step();
        reset = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready), 64'd1);
        stale = 0;
        repeat (40) begin
            step();
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'd0);
        do_op(32'd1, 32'd1, 4'h4, 2'b00, 4'h0, lat);
        expect_res("post_rst_add", lat, 1, 64'd2, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
